// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline hold codes plus the local types for the skid-buffered pipeline stage.
`ifndef PIPE_HOLD_DEFINES_SV
`define PIPE_HOLD_DEFINES_SV
`define HOLDPIP_BUS 2:0
`define HOLD_WAIT   3'b001
`define HOLD_FLUSH  3'b010
`endif

package pipe_skid_stage_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Number of beats held for a given state.
    function automatic logic [OCC_W-1:0] occ_of(input skid_state_e s);
        logic [OCC_W-1:0] occ;
        occ = OCC_W'(0);
        case (s)
            ST_BUSY: occ = OCC_W'(1);
            ST_FULL: occ = OCC_W'(2);
            default: occ = OCC_W'(0);
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage with flush/freeze control and a saturating stall counter.
// in_ready_o depends only on registered state and hold, so no combinational ready path crosses the stage.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned     DW      = 32,
    parameter logic [DW-1:0]   DEFAULT = {DW{1'b0}},
    parameter int unsigned     CW      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [`HOLDPIP_BUS] hold_flag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DW-1:0]       in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DW-1:0]       out_data_o,
    output logic [OCC_W-1:0]    occupancy_o,
    output logic [CW-1:0]       stall_cnt_o
);

    localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};

    skid_state_e   state, state_nxt;
    logic [DW-1:0] main_q, main_nxt;
    logic [DW-1:0] skid_q, skid_nxt;
    logic          hold_flush;
    logic          hold_wait;
    logic          hold_run;
    logic          in_fire;
    logic          out_fire;

    assign hold_flush = (hold_flag_i == `HOLD_FLUSH);
    assign hold_wait  = (hold_flag_i == `HOLD_WAIT);
    assign hold_run   = !hold_flush && !hold_wait;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;
    assign out_data_o = main_q;

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            main_q <= DEFAULT;
            skid_q <= DEFAULT;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Next state and payload moves; flush overrides everything, freeze masks both handshakes.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (hold_flush) begin
            state_nxt = ST_EMPTY;
            main_nxt  = DEFAULT;
            skid_nxt  = DEFAULT;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_BUSY;
                        main_nxt  = in_data_i;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data_i;
                    end else if (in_fire) begin
                        state_nxt = ST_FULL;
                        skid_nxt  = in_data_i;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                        main_nxt  = DEFAULT;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_nxt = ST_BUSY;
                        main_nxt  = skid_q;
                        skid_nxt  = DEFAULT;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_nxt  = DEFAULT;
                    skid_nxt  = DEFAULT;
                end
            endcase
        end
    end

    // Handshake and occupancy outputs; ready is held low for as long as reset is asserted.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        occupancy_o = occ_of(state);
        if (rst_n && hold_run && (state != ST_FULL)) begin
            in_ready_o = 1'b1;
        end
        if (hold_run && (state != ST_EMPTY)) begin
            out_valid_o = 1'b1;
        end
    end

    // Backpressure cycles, saturating; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_o != STALL_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CW'(1);
        end
    end

endmodule
